// File: rtl/sys_mem_pkg.sv
// sys_mem_pkg: shared state encoding, lane constants and request checks for the system-memory responder
package sys_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int DATA_W = LANE_W * LANES;

    // A request is rejected when misaligned, past the end of the array, or with no lanes enabled
    function automatic logic req_error(input logic [31:0] addr, input logic [LANES-1:0] be,
                                       input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= 34'(depth_words) * 34'd4) || (be == '0);
    endfunction

    // Expand byte enables into a full-width bit mask
    function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) m[i*LANE_W +: LANE_W] = {LANE_W{be[i]}};
        return m;
    endfunction

endpackage

// File: rtl/sys_mem_responder_if.sv
// sys_mem_responder_if: request/response handshake bundle between the processor and the memory responder
interface sys_mem_responder_if #(parameter int ADDR_W = 16) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/sys_mem_word_array.sv
// sys_mem_word_array: word-organised synchronous RAM with byte-lane write enables and a registered read port
module sys_mem_word_array
    import sys_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [LANES-1:0]  be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Read output only updates on a read access so it stays put for the response stage
    always_comb rdata_d = (en && !we) ? mem_q[addr] : rdata_q;

    // Array contents are deliberately not reset; writes touch only enabled lanes
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we)
            for (int i = 0; i < LANES; i++)
                if (be[i]) mem_q[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sys_mem_responder.sv
// sys_mem_responder: single-outstanding memory responder with wait states, byte-lane access and error responses
module sys_mem_responder
    import sys_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 2
) (
    input logic               clk,
    input logic               rst,
    sys_mem_responder_if.slave bus
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               we_q, we_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [LANES-1:0]   be_q, be_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [31:0]        addr_in;
    logic [DATA_W-1:0]  ram_rdata;

    assign addr_in = 32'(bus.req_addr);

    sys_mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
        .clk  (clk),
        .en   (state_q == ST_ACCESS),
        .we   (we_q),
        .be   (be_q),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // Next-state, request latch and response staging; the first RESP cycle captures the
    // registered array output so rsp_* come straight from flops and cannot glitch
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        we_d        = we_q;
        idx_d       = idx_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    idx_d   = addr_in[AW+1:2];
                    be_d    = bus.req_be;
                    wdata_d = bus.req_wdata;
                    err_d   = req_error(addr_in, bus.req_be, DEPTH_WORDS);
                    count_d = '0;
                    state_d = err_d ? ST_RESP : ((WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS);
                end
            end
            ST_WAIT: begin
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_LAST) state_d = ST_ACCESS;
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (err_q || we_q) ? '0 : (ram_rdata & lane_mask(be_q));
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sys_mem_responder.sv
// tb_sys_mem_responder: scoreboard bench for two responders (WAIT_STATES=2 and WAIT_STATES=0)
module tb_sys_mem_responder;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rsp_rdy = 1'b1;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   acc [2];
    logic in_rsp [2];
    logic [31:0] cap_dat [2];
    logic cap_err [2];
    exp_t exp_q [$];

    sys_mem_responder_if #(.ADDR_W(16)) b2 ();
    sys_mem_responder_if #(.ADDR_W(16)) b0 ();

    sys_mem_responder #(.ADDR_W(16), .DEPTH_WORDS(4096), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(b2)
    );
    sys_mem_responder #(.ADDR_W(16), .DEPTH_WORDS(4096), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    assign b2.rsp_ready = rsp_rdy;
    assign b0.rsp_ready = rsp_rdy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic logic s_ready(input int d);
        return d == 0 ? b2.req_ready : b0.req_ready;
    endfunction
    function automatic logic s_busy(input int d);
        return d == 0 ? b2.busy : b0.busy;
    endfunction
    function automatic logic s_valid(input int d);
        return d == 0 ? b2.rsp_valid : b0.rsp_valid;
    endfunction
    function automatic logic s_err(input int d);
        return d == 0 ? b2.rsp_err : b0.rsp_err;
    endfunction
    function automatic logic [31:0] s_rdata(input int d);
        return d == 0 ? b2.rsp_rdata : b0.rsp_rdata;
    endfunction

    task automatic drive(input int d, input logic v, input logic we, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (d == 0) begin
            b2.req_valid = v; b2.req_we = we; b2.req_addr = a; b2.req_be = be; b2.req_wdata = wd;
        end else begin
            b0.req_valid = v; b0.req_we = we; b0.req_addr = a; b0.req_be = be; b0.req_wdata = wd;
        end
    endtask

    // Present a request at a negedge while the DUT is idle; it is taken at the next posedge
    task automatic issue(input int d, input logic we, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        int n = 0;
        while (!s_ready(d) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("issue timeout", 32'(n), 32'(0));
        drive(d, 1'b1, we, a, be, wd);
        @(posedge clk);
        @(negedge clk);
        acc[d] = cyc;
        drive(d, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (s_busy(d) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("done timeout", 32'(n), 32'(0));
    endtask

    task automatic req(input int d, input logic we, input logic [15:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] xr, input logic xe, input string nm);
        exp_t e;
        e.d = d; e.rdata = xr; e.err = xe; e.name = nm;
        e.lat = xe ? 1 : (d == 0 ? 4 : 2);
        exp_q.push_back(e);
        issue(d, we, a, be, wd);
        wait_done(d);
    endtask

    // Monitor: pops an expectation when rsp_valid rises, then watches the held response
    always @(negedge clk) begin
        exp_t ex;
        if (!rst) begin
            in_rsp[0] = 1'b0;
            in_rsp[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (s_valid(d) && !in_rsp[d]) begin
                    in_rsp[d] = 1'b1;
                    cap_dat[d] = s_rdata(d);
                    cap_err[d] = s_err(d);
                    if (exp_q.size() == 0 || exp_q[0].d != d) begin
                        chk("unexpected response", 32'(d), 32'hFFFF_FFFF);
                    end else begin
                        ex = exp_q.pop_front();
                        chk({ex.name, " rdata"}, s_rdata(d), ex.rdata);
                        chk({ex.name, " err"}, 32'(s_err(d)), 32'(ex.err));
                        chk({ex.name, " latency"}, 32'(cyc - acc[d]), 32'(ex.lat));
                    end
                end else if (in_rsp[d]) begin
                    if (!s_valid(d)) begin
                        chk("valid dropped", 32'(s_valid(d)), 32'(1));
                    end else begin
                        chk("held rdata", s_rdata(d), cap_dat[d]);
                        chk("held err", 32'(s_err(d)), 32'(cap_err[d]));
                        chk("held req_ready", 32'(s_ready(d)), 32'(0));
                    end
                end
                if (!s_valid(d) || rsp_rdy) in_rsp[d] = in_rsp[d] && s_valid(d) && !rsp_rdy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_rsp[0] = 1'b0;
        in_rsp[1] = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(b2.req_ready), 32'(1));
        chk("reset busy", 32'(b2.busy), 32'(0));
        chk("reset rsp_valid", 32'(b2.rsp_valid), 32'(0));
        chk("reset rsp_rdata", b2.rsp_rdata, 32'h0);
        chk("reset rsp_err", 32'(b2.rsp_err), 32'(0));
        rst = 1'b1;
        @(negedge clk);

        // Full-word write/read, partial-lane write and masked reads
        req(0, 1, 16'h0010, 4'b1111, 32'hDEADBEEF, 32'h0, 0, "wr10");
        req(0, 0, 16'h0010, 4'b1111, 32'h0, 32'hDEADBEEF, 0, "rd10");
        req(0, 1, 16'h0010, 4'b0010, 32'h0000AA00, 32'h0, 0, "wr10 lane1");
        req(0, 0, 16'h0010, 4'b1111, 32'h0, 32'hDEADAAEF, 0, "rd10 merged");
        req(0, 0, 16'h0010, 4'b0101, 32'h0, 32'h00AD00EF, 0, "rd10 be0101");

        // Error cases: misaligned, out of range, no lanes; none may touch the array
        req(0, 0, 16'h0011, 4'b1111, 32'h0, 32'h0, 1, "rd misaligned");
        req(0, 0, 16'h0010, 4'b1111, 32'h0, 32'hDEADAAEF, 0, "rd10 after err");
        req(0, 1, 16'h0000, 4'b1111, 32'hA5A5A5A5, 32'h0, 0, "wr00");
        req(0, 1, 16'h0020, 4'b1111, 32'hCAFEF00D, 32'h0, 0, "wr20");
        req(0, 1, 16'h4000, 4'b1111, 32'h11111111, 32'h0, 1, "wr oor");
        req(0, 0, 16'h4000, 4'b1111, 32'h0, 32'h0, 1, "rd oor");
        req(0, 1, 16'h0020, 4'b0000, 32'hFFFFFFFF, 32'h0, 1, "wr be0");
        req(0, 1, 16'h0022, 4'b1111, 32'hFFFFFFFF, 32'h0, 1, "wr misaligned");
        req(0, 0, 16'h0000, 4'b1111, 32'h0, 32'hA5A5A5A5, 0, "rd00 intact");
        req(0, 0, 16'h0020, 4'b1111, 32'h0, 32'hCAFEF00D, 0, "rd20 intact");

        // Back-pressure: response must be held while rsp_ready is low
        rsp_rdy = 1'b0;
        exp_q.push_back('{0, 32'hDEADAAEF, 1'b0, 4, "rd10 hold"});
        issue(0, 0, 16'h0010, 4'b1111, 32'h0);
        repeat (14) @(negedge clk);
        chk("hold rsp_valid", 32'(b2.rsp_valid), 32'(1));
        rsp_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post-hold req_ready", 32'(b2.req_ready), 32'(1));
        chk("post-hold rsp_valid", 32'(b2.rsp_valid), 32'(0));

        // Reset during WAIT of a write: array keeps the old word
        req(0, 1, 16'h0030, 4'b1111, 32'h12345678, 32'h0, 0, "wr30");
        issue(0, 1, 16'h0030, 4'b1111, 32'h99999999);
        rst = 1'b0;
        @(negedge clk);
        chk("mid-reset busy", 32'(b2.busy), 32'(0));
        chk("mid-reset rsp_valid", 32'(b2.rsp_valid), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready", 32'(b2.req_ready), 32'(1));
        req(0, 0, 16'h0030, 4'b1111, 32'h0, 32'h12345678, 0, "rd30 after reset");

        // Zero wait states: latency 2, errors still 1
        req(1, 1, 16'h0030, 4'b1111, 32'h12345678, 32'h0, 0, "ws0 wr30");
        req(1, 0, 16'h0030, 4'b1111, 32'h0, 32'h12345678, 0, "ws0 rd30");
        req(1, 1, 16'h0030, 4'b1000, 32'hAB000000, 32'h0, 0, "ws0 wr30 lane3");
        req(1, 0, 16'h0030, 4'b1001, 32'h0, 32'hAB000078, 0, "ws0 rd30 be1001");
        req(1, 0, 16'h3FFF, 4'b1111, 32'h0, 32'h0, 1, "ws0 misaligned");
        req(1, 0, 16'h3FFC, 4'b1111, 32'h0, 32'h0, 0, "ws0 last word");
        req(1, 1, 16'h0030, 4'b1111, 32'h12345678, 32'h0, 0, "ws0 restore30");

        // Reset during ACCESS (before its edge) of a zero-wait write
        issue(1, 1, 16'h0030, 4'b1111, 32'h99999999);
        rst = 1'b0;
        @(negedge clk);
        chk("ws0 mid-reset busy", 32'(b0.busy), 32'(0));
        chk("ws0 mid-reset rsp_valid", 32'(b0.rsp_valid), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        req(1, 0, 16'h0030, 4'b1111, 32'h0, 32'h12345678, 0, "ws0 rd30 after reset");

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
